// File: rtl/keypad_reader.sv
// 4x4 matrix keypad reader: row scan, full-scan debounce, 8-digit hex edit buffer, MMIO read port.
// Latency: key event on the clock that completes the DB_SCANS-th matching scan; rdata is combinational.
// Backpressure: none; a new enter overwrites data_reg, and a DATA read clears key_ready unless an enter lands the same cycle.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   row_out[3:0]      active-low row drive, one row low at a time
//   col_in[3:0]       active-low column sense, already synchronised
//   address, rd_en    CPU IO address and one-cycle read strobe
//   rdata[31:0]       read data, combinational from address
//   key_ready         committed value not yet read
//   digit_cnt[3:0]    digits currently held in the edit buffer (0-8)
module keypad_reader #(
    parameter int          SCAN_DIV  = 50000,
    parameter int          DB_SCANS  = 4,
    parameter logic [31:0] DATA_ADDR = 32'hFFFF_FFF3,
    parameter logic [31:0] STAT_ADDR = 32'hFFFF_FFF1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_out,
    input  logic [3:0]  col_in,
    input  logic [31:0] address,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        key_ready,
    output logic [3:0]  digit_cnt
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DB_SCANS + 1);

    typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED} state_t;

    logic [SW-1:0] r_slot;
    logic [1:0]    r_ri;
    logic [1:0]    r_hits;      // keys seen so far this scan, saturating at 2
    logic [3:0]    r_code;      // code of the first key seen this scan
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [CW-1:0] r_rel, w_rel_nxt;
    logic [3:0]    r_cand, w_cand_nxt;
    logic [31:0]   r_edit;
    logic [31:0]   r_data;
    logic [3:0]    r_digits;
    logic          r_ready;

    logic          w_slot_end;
    logic          w_scan_done;
    logic [3:0]    w_low;
    logic [2:0]    w_row_hits;
    logic [1:0]    w_col_idx;
    logic [2:0]    w_sum;
    logic [1:0]    w_tot;
    logic [3:0]    w_code;
    logic          w_none;
    logic          w_one;
    logic          w_key_evt;
    logic [3:0]    w_key_code;
    logic          w_data_rd;

    assign row_out    = ~(4'b0001 << r_ri);
    assign w_slot_end = (r_slot == SW'(SCAN_DIV - 1));
    assign w_scan_done = w_slot_end && (r_ri == 2'd3);

    // Classification of the sample taken this cycle, folded into the running scan totals.
    assign w_low      = ~col_in;
    assign w_row_hits = {2'b00, w_low[0]} + {2'b00, w_low[1]} + {2'b00, w_low[2]} + {2'b00, w_low[3]};

    always_comb begin
        if (w_low[0])      w_col_idx = 2'd0;
        else if (w_low[1]) w_col_idx = 2'd1;
        else if (w_low[2]) w_col_idx = 2'd2;
        else               w_col_idx = 2'd3;
    end

    assign w_sum  = {1'b0, r_hits} + w_row_hits;
    assign w_tot  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    // Only meaningful when the scan total is exactly one key.
    assign w_code = (r_hits == 2'd0) ? {r_ri, w_col_idx} : r_code;
    assign w_none = (w_tot == 2'd0);
    assign w_one  = (w_tot == 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
            r_ri   <= 2'd0;
            r_hits <= 2'd0;
            r_code <= 4'd0;
        end else if (w_slot_end) begin
            r_slot <= '0;
            r_ri   <= r_ri + 2'd1;
            r_hits <= (r_ri == 2'd3) ? 2'd0 : w_tot;
            r_code <= w_code;
        end else begin
            r_slot <= r_slot + SW'(1);
        end
    end

    // Debounce FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rel   <= '0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rel   <= w_rel_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // Debounce FSM: next state, advancing once per completed scan.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rel_nxt   = r_rel;
        w_cand_nxt  = r_cand;
        if (w_scan_done) begin
            case (r_state)
                S_IDLE: begin
                    if (w_one) begin
                        w_cand_nxt = w_code;
                        if (DB_SCANS == 1) begin
                            w_state_nxt = S_PRESSED;
                            w_rel_nxt   = '0;
                        end else begin
                            w_state_nxt = S_CAND;
                            w_cnt_nxt   = CW'(1);
                        end
                    end
                end
                S_CAND: begin
                    if (w_one && (w_code == r_cand)) begin
                        if (r_cnt + CW'(1) == CW'(DB_SCANS)) begin
                            w_state_nxt = S_PRESSED;
                            w_rel_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (w_none) begin
                        if (r_rel + CW'(1) == CW'(DB_SCANS)) w_state_nxt = S_IDLE;
                        else                                 w_rel_nxt   = r_rel + CW'(1);
                    end else begin
                        w_rel_nxt = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Debounce FSM: outputs. The event fires on the transition into PRESSED.
    always_comb begin
        w_key_evt  = 1'b0;
        w_key_code = r_cand;
        if (w_scan_done && w_one) begin
            case (r_state)
                S_IDLE: begin
                    if (DB_SCANS == 1) begin
                        w_key_evt  = 1'b1;
                        w_key_code = w_code;
                    end
                end
                S_CAND: begin
                    if ((w_code == r_cand) && (r_cnt + CW'(1) == CW'(DB_SCANS))) w_key_evt = 1'b1;
                end
                default: w_key_evt = 1'b0;
            endcase
        end
    end

    assign w_data_rd = rd_en && (address == DATA_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edit   <= 32'd0;
            r_data   <= 32'd0;
            r_digits <= 4'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_data_rd) r_ready <= 1'b0;
            if (w_key_evt) begin
                if (w_key_code <= 4'hD) begin
                    if (r_digits < 4'd8) begin
                        r_edit   <= {r_edit[27:0], w_key_code};
                        r_digits <= r_digits + 4'd1;
                    end
                end else if (w_key_code == 4'hE) begin
                    if (r_digits != 4'd0) begin
                        r_edit   <= r_edit >> 4;
                        r_digits <= r_digits - 4'd1;
                    end
                end else begin
                    // Enter: a commit in the same cycle as a clearing read keeps key_ready set.
                    r_data   <= r_edit;
                    r_ready  <= 1'b1;
                    r_edit   <= 32'd0;
                    r_digits <= 4'd0;
                end
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (address == DATA_ADDR)      rdata = r_data;
        else if (address == STAT_ADDR) rdata = {27'd0, r_digits, r_ready};
    end

    assign key_ready = r_ready;
    assign digit_cnt = r_digits;

endmodule
